// File: rtl/mixcolumns_iter.sv
// Iterative AES MixColumns/InvMixColumns with bypass; COLS_PER_CYCLE columns per clock.
// Latency NB/COLS_PER_CYCLE+1 cycles (bypass 1); result held in DONE until o_ready.
module mixcolumns_iter #(
  parameter int NB             = 4,
  parameter int WORD           = 8,
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  output logic                   i_ready,
  input  logic [NB*4*WORD-1:0]   i_block,
  input  logic                   i_inv,
  input  logic                   i_bypass,
  output logic                   o_valid,
  input  logic                   o_ready,
  output logic [NB*4*WORD-1:0]   o_block,
  output logic                   o_busy
);

  localparam int BW = NB*4*WORD;
  localparam logic [2:0] STEP     = 3'(COLS_PER_CYCLE);
  localparam logic [2:0] LAST_CNT = 3'(NB - COLS_PER_CYCLE);

  generate
    if (NB != 4 || WORD != 8 ||
        !(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_param
      $error("mixcolumns_iter: unsupported NB/WORD/COLS_PER_CYCLE");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   work_q, work_d;
  logic [BW-1:0]   o_block_q, o_block_d;
  logic            inv_q, inv_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            accept;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Inverse coefficients decompose as 0E=8^4^2, 0B=8^2^1, 0D=8^4^1, 09=8^1.
  function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv);
    logic [7:0] a [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv)
        r[31-8*i -: 8] = (m8[i] ^ m4[i] ^ m2[i])
                       ^ (m8[(i+1)%4] ^ m2[(i+1)%4] ^ a[(i+1)%4])
                       ^ (m8[(i+2)%4] ^ m4[(i+2)%4] ^ a[(i+2)%4])
                       ^ (m8[(i+3)%4] ^ a[(i+3)%4]);
      else
        r[31-8*i -: 8] = m2[i] ^ m2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
    return r;
  endfunction

  assign accept = i_valid & i_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      o_block_q <= '0;
      inv_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      o_block_q <= o_block_d;
      inv_q     <= inv_d;
      cnt_q     <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    o_block_d = o_block_q;
    inv_d     = inv_q;
    cnt_d     = cnt_q;
    case (state_q)
      CALC: begin
        for (int c = 0; c < NB; c++) begin
          if (3'(c) >= cnt_q && 3'(c) < cnt_q + STEP)
            work_d[BW-1-32*c -: 32] = mix_col(work_q[BW-1-32*c -: 32], inv_q);
        end
        cnt_d = cnt_q + STEP;
        if (cnt_q == LAST_CNT) begin
          state_d   = DONE;
          o_block_d = work_d;
        end
      end
      DONE: begin
        if (o_ready)
          state_d = IDLE;
      end
      default: ;
    endcase
    // A new block may be accepted in IDLE or in the same cycle DONE drains.
    if (accept) begin
      work_d = i_block;
      inv_d  = i_inv;
      cnt_d  = '0;
      if (i_bypass) begin
        state_d   = DONE;
        o_block_d = i_block;
      end else begin
        state_d = CALC;
      end
    end
  end

  always_comb begin
    i_ready = (state_q == IDLE) | ((state_q == DONE) & o_ready);
    o_valid = (state_q == DONE);
    o_busy  = (state_q != IDLE);
  end

  assign o_block = o_block_q;

endmodule
